// File: rtl/sa_feature_fetch_ctrl.sv
// sa_feature_fetch_ctrl: walks cnt 0..CNT_LAST through the external feature
// address decoder, reads feature memory at the decoded address and streams
// the returned words to the systolic array via a 2-entry skid FIFO.
// Optional feature macro: SA_FETCH_STALL_CNT_EN adds the stall_cycles counter.
module sa_feature_fetch_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned CNT_LAST = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        cnt,
    input  logic [ADDR_W-1:0] dec_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              feat_valid,
    output logic [DATA_W-1:0] feat_data,
`ifdef SA_FETCH_STALL_CNT_EN
    output logic [15:0]       stall_cycles,
`endif
    input  logic              feat_ready
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned OCC_W   = 2;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inflight_q, inflight_d;
    logic [OCC_W-1:0]   fifo_occ_q, fifo_occ_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  fifo_mem_q [2];
    logic [DATA_W-1:0]  fifo_mem_d [2];
    logic               done_q, done_d;
    logic               busy_q, busy_d;
`ifdef SA_FETCH_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;
`endif

    logic               pop;
    logic               credit_ok;
    logic               rd_en;
    logic [2:0]         credit_sum;

    // Handshake and read-credit evaluation for the current cycle
    always_comb begin
        pop        = (fifo_occ_q != '0) && feat_ready;
        credit_sum = 3'(fifo_occ_q) + 3'(inflight_q) - 3'(pop);
        credit_ok  = credit_sum < 3'd2;
        rd_en      = (state_q == FETCH) && credit_ok;
    end

    // Next-state logic for FSM, counter, FIFO and status flags
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        inflight_d  = rd_en;
        fifo_occ_d  = fifo_occ_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_mem_d  = fifo_mem_q;
`ifdef SA_FETCH_STALL_CNT_EN
        stall_d     = stall_q;
`endif

        // Read data lands one cycle after its strobe
        if (inflight_q) begin
            fifo_mem_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        fifo_occ_d = OCC_W'(fifo_occ_q + OCC_W'(inflight_q) - OCC_W'(pop));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = FETCH;
`ifdef SA_FETCH_STALL_CNT_EN
                    stall_d = '0;
`endif
                end
            end
            FETCH: begin
                if (rd_en) begin
                    if (cnt_q == CNT_W'(CNT_LAST)) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
            end
            DRAIN: begin
                // Look at post-edge occupancy so done follows the last pop directly
                if ((fifo_occ_d == '0) && !inflight_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SA_FETCH_STALL_CNT_EN
        if (busy_q && (fifo_occ_q != '0) && !feat_ready && (stall_q != '1)) begin
            stall_d = STALL_W'(stall_q + STALL_W'(1));
        end
`endif

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            inflight_q    <= 1'b0;
            fifo_occ_q    <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SA_FETCH_STALL_CNT_EN
            stall_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            inflight_q    <= inflight_d;
            fifo_occ_q    <= fifo_occ_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            done_q        <= done_d;
            busy_q        <= busy_d;
`ifdef SA_FETCH_STALL_CNT_EN
            stall_q       <= stall_d;
`endif
        end
    end

    // Output mapping; the read strobe must react to a same-cycle pop
    always_comb begin
        busy       = busy_q;
        done       = done_q;
        cnt        = cnt_q;
        mem_rd_en  = rd_en;
        mem_addr   = dec_addr;
        feat_valid = fifo_occ_q != '0;
        feat_data  = fifo_mem_q[rd_ptr_q];
`ifdef SA_FETCH_STALL_CNT_EN
        stall_cycles = stall_q;
`endif
    end

endmodule

// File: tb/tb_sa_feature_fetch_ctrl.sv
// Self-checking bench for sa_feature_fetch_ctrl with a transaction-level
// reference model (words issued / words popped bookkeeping).
module tb_sa_feature_fetch_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              feat_ready = 1'b0;
    logic              busy, done, mem_rd_en, feat_valid;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] dec_addr, mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] feat_data;
`ifdef SA_FETCH_STALL_CNT_EN
    logic [15:0]       stall_cycles;
`endif

    sa_feature_fetch_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cnt        (cnt),
        .dec_addr   (dec_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
`ifdef SA_FETCH_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .feat_ready (feat_ready)
    );

    always #5 clk = ~clk;

    logic [ADDR_W-1:0] dec_tab [16];
    logic [DATA_W-1:0] tb_mem  [64];
    logic [DATA_W-1:0] golden  [9];

    assign dec_addr = dec_tab[cnt];

    // Feature memory: one-cycle read latency
    always @(posedge clk) if (mem_rd_en === 1'b1) mem_rdata <= tb_mem[mem_addr];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a pass is 9 ordered words; a word is visible two
    // cycles after its read; reads allowed while outstanding words < 2.
    bit m_act   = 1'b0;
    int m_iss   = 0;
    int m_prev  = 0;
    int m_pop   = 0;
    int m_stall = 0;

    int tcyc = 0;
    int start_tc = 0;
    int dut_done_tc = 0;
    int n_dut_done = 0;
    logic [DATA_W-1:0] cap [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, tcyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] word(input int k);
        return tb_mem[dec_tab[k]];
    endfunction

    // One clock cycle: apply inputs, check outputs at negedge, advance model
    task automatic cycle(input logic st, input logic rdy, input logic rstn);
        int   arrived;
        int   exp_cnt;
        logic ev, pop, erd, edn;
        start = st; feat_ready = rdy; reset_n = rstn;
        if (!rstn) begin
            m_act = 1'b0; m_iss = 0; m_prev = 0; m_pop = 0; m_stall = 0;
        end
        arrived = m_prev;
        ev      = arrived > m_pop;
        pop     = ev && rdy;
        erd     = m_act && (m_iss < 9) && ((m_iss - m_pop - int'(pop)) < 2);
        edn     = m_act && (m_pop == 9);
        exp_cnt = (m_iss > 8) ? 8 : m_iss;
        @(negedge clk);
        chk("feat_valid", 32'(feat_valid), 32'(ev));
        if (ev) chk("feat_data", 32'(feat_data), 32'(word(m_pop)));
        if (!rstn) chk("feat_data_rst", 32'(feat_data), 32'd0);
        chk("mem_rd_en", 32'(mem_rd_en), 32'(erd));
        chk("cnt", 32'(cnt), 32'(exp_cnt));
        chk("mem_addr", 32'(mem_addr), 32'(dec_tab[exp_cnt]));
        chk("done", 32'(done), 32'(edn));
        chk("busy", 32'(busy), 32'(m_act));
        chk("fifo_occ", 32'(dut.fifo_occ_q), 32'(arrived - m_pop));
        chk("fifo_occ_le2", 32'(dut.fifo_occ_q <= 2'd2), 32'd1);
`ifdef SA_FETCH_STALL_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
        if (pop) cap.push_back(feat_data);
        if (done === 1'b1) begin
            dut_done_tc = tcyc;
            n_dut_done++;
        end
        @(posedge clk);
        if (rstn) begin
            if (st && !m_act) begin
                m_act = 1'b1; m_iss = 0; m_prev = 0; m_pop = 0; m_stall = 0;
            end else if (m_act) begin
                if (ev && !rdy) m_stall++;
                m_prev = m_iss;
                m_iss  = m_iss + int'(erd);
                m_pop  = m_pop + int'(pop);
                if (edn) m_act = 1'b0;
            end
        end
        tcyc++;
        #1;
    endtask

    // mode 0: ready high; 1: ready low cycles 3-7; 2: ready toggles;
    // 3: ready high with start re-pulsed at 4 and 12; 4: random ready/start
    task automatic run_pass(input int mode);
        logic st, rdy;
        cap.delete();
        n_dut_done = 0;
        start_tc   = tcyc;
        for (int c = 0; c < 200; c++) begin
            st  = (c == 0);
            rdy = 1'b1;
            case (mode)
                1: rdy = !(c >= 3 && c <= 7);
                2: rdy = (c % 2) == 1;
                3: st  = (c == 0) || (c == 4) || (c == 12);
                4: begin
                    rdy = $urandom_range(0, 3) != 0;
                    st  = (c == 0) || ($urandom_range(0, 5) == 0);
                end
                default: ;
            endcase
            cycle(st, rdy, 1'b1);
            if (c > 0 && !m_act) break;
        end
        chk("pass_ended_busy", 32'(busy), 32'd0);
        chk("pass_done_count", 32'(n_dut_done), 32'd1);
        chk("pass_word_count", 32'(cap.size()), 32'd9);
    endtask

    task automatic check_golden(input string tag);
        for (int i = 0; i < 9; i++) begin
            if (i < cap.size()) chk(tag, 32'(cap[i]), 32'(golden[i]));
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] dtab [9];
        dtab = '{6'd8, 6'd4, 6'd9, 6'd0, 6'd5, 6'd10, 6'd1, 6'd6, 6'd2};
        for (int i = 0; i < 16; i++) dec_tab[i] = (i < 9) ? dtab[i] : 6'd0;
        for (int i = 0; i < 64; i++) tb_mem[i] = DATA_W'(8'h10 + i);
        golden = '{8'h18, 8'h14, 8'h19, 8'h10, 8'h15, 8'h1A, 8'h11, 8'h16, 8'h12};

        // Reset state
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);

        // Streaming pass with ready held high
        run_pass(0);
        check_golden("pass_ready_hi_data");
        chk("pass_ready_hi_done_cycle", 32'(dut_done_tc - start_tc), 32'd12);

        // Back-pressure in cycles 3-7
        run_pass(1);
        check_golden("pass_stall_data");
        chk("pass_stall_done_cycle", 32'(dut_done_tc - start_tc), 32'd17);
`ifdef SA_FETCH_STALL_CNT_EN
        chk("pass_stall_count", 32'(stall_cycles), 32'd5);
`endif
        cycle(1'b0, 1'b1, 1'b1);

        // Ready toggling every cycle
        run_pass(2);
        check_golden("pass_toggle_data");

        // Start re-pulsed during busy and in the done cycle
        run_pass(3);
        check_golden("pass_restart_data");
        chk("pass_restart_done_cycle", 32'(dut_done_tc - start_tc), 32'd12);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);

        // Reset asserted mid-pass in cycle 6 for two cycles
        cycle(1'b1, 1'b1, 1'b1);
        for (int c = 1; c < 6; c++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_cnt", 32'(cnt), 32'd0);
        run_pass(0);
        check_golden("pass_after_reset_data");

        // Back-to-back passes: start in the cycle after done
        run_pass(0);
        check_golden("b2b_first_data");
        run_pass(0);
        check_golden("b2b_second_data");
        chk("b2b_second_done_cycle", 32'(dut_done_tc - start_tc), 32'd12);

        // Randomized memory contents, ready and start activity
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 64; i++) tb_mem[i] = DATA_W'($urandom);
            run_pass(4);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++)
                cycle(1'b0, 1'($urandom), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
